// File: rtl/ultrasonic_scan_scheduler_pkg.sv
// Shared types, default timing and the cycles-to-centimetres conversion
// for the round-robin ultrasonic ranger scheduler.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      TRIGGER,
      WAIT_ECHO,
      COUNT,
      STORE,
      GAP
   } state_t;

   localparam int          CNT_W            = 22;
   localparam int          DEF_N_CH         = 4;
   localparam int          DEF_TRIG_CYCLES  = 500;
   localparam int          DEF_WAIT_TIMEOUT = 1_500_000;
   localparam int          DEF_ECHO_MAX     = 1_900_000;
   localparam int          DEF_GAP_CYCLES   = 3_000_000;
   localparam logic [31:0] DEF_CM_SCALE     = 32'h0000_1648;
   localparam logic [7:0]  DIST_OOR         = 8'hFF;

   // scale is unsigned Q8.24 cm per cycle; results beyond one byte clip to DIST_OOR
   function automatic logic [7:0] cycles_to_cm(input logic [CNT_W-1:0] cycles,
                                               input logic [31:0]      scale);
      logic [53:0] product;
      logic [29:0] cm;
      product = 54'(cycles) * 54'(scale);
      cm      = product[53:24];
      return (cm > 30'd255) ? DIST_OOR : cm[7:0];
   endfunction

endpackage

// File: rtl/ultrasonic_scan_scheduler_if.sv
// Per-channel sensor pins and result bus between the scheduler and the board/display side.
interface ultrasonic_scan_scheduler_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]   echo;
   logic [N_CH-1:0]   trig;
   logic [8*N_CH-1:0] distance;
   logic [N_CH-1:0]   dist_valid;
   logic [N_CH-1:0]   timeout;

   modport master (input echo, output trig, distance, dist_valid, timeout);
   modport slave  (output echo, input trig, distance, dist_valid, timeout);
endinterface

// File: rtl/ultrasonic_scan_scheduler_echo_sync.sv
// Two-flop synchronizer for the raw echo pins; data path carries no reset.
module echo_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o
);
   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk) begin
      meta_q <= async_i;
      sync_q <= meta_q;
   end

   assign sync_o = sync_q;
endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin ultrasonic ranger scheduler: one ping at a time, echo timed and stored per channel.
//   state     | meaning
//   IDLE      | not scanning
//   SELECT    | pick next masked-in channel from pointer
//   TRIGGER   | trig pin high for TRIG_CYCLES
//   WAIT_ECHO | wait for echo rise, bounded by WAIT_TIMEOUT
//   COUNT     | count echo-high cycles, bounded by ECHO_MAX
//   STORE     | write slot, pulse dist_valid/scan_done
//   GAP       | settle for GAP_CYCLES before next channel
module ultrasonic_scan_scheduler
   import ultrasonic_pkg::*;
#(
   parameter int          N_CH         = DEF_N_CH,
   parameter int          TRIG_CYCLES  = DEF_TRIG_CYCLES,
   parameter int          WAIT_TIMEOUT = DEF_WAIT_TIMEOUT,
   parameter int          ECHO_MAX     = DEF_ECHO_MAX,
   parameter int          GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter logic [31:0] CM_SCALE     = DEF_CM_SCALE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable_i,
   input  logic [N_CH-1:0]             ch_mask_i,
   ultrasonic_scan_scheduler_if.master bus_if,
   output logic [2:0]                  active_ch_o,
   output logic                        busy_o,
   output logic                        scan_done_o
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0]  echo_cnt_q, echo_cnt_d;
   logic [2:0]        active_q, active_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic [N_CH-1:0]   trig_q, trig_d;
   logic [N_CH-1:0]   dist_valid_q, dist_valid_d;
   logic [N_CH-1:0]   timeout_q, timeout_d;
   logic [8*N_CH-1:0] distance_q, distance_d;
   logic              tmo_flag_q, tmo_flag_d;
   logic              scan_done_q, scan_done_d;

   logic [N_CH-1:0]   echo_s;
   logic [7:0]        echo8;
   logic              act_echo;
   logic              sel_found;
   logic [2:0]        sel_ch;
   logic              mask_above;

   echo_sync #(.W(N_CH)) u_echo_sync (
      .clk     (clk),
      .async_i (bus_if.echo),
      .sync_o  (echo_s)
   );

   assign echo8    = 8'(echo_s);
   assign act_echo = echo8[active_q];

   // first masked-in channel at or after the pointer, wrapping modulo N_CH
   always_comb begin
      logic [7:0] mask8;
      logic [3:0] sum;
      mask8     = 8'(ch_mask_i);
      sum       = '0;
      sel_found = 1'b0;
      sel_ch    = '0;
      for (int i = 0; i < N_CH; i++) begin
         sum = {1'b0, ptr_q} + 4'(i);
         if (sum >= 4'(N_CH)) sum = sum - 4'(N_CH);
         if (!sel_found && mask8[sum[2:0]]) begin
            sel_found = 1'b1;
            sel_ch    = sum[2:0];
         end
      end
   end

   always_comb begin
      mask_above = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if ((3'(k) > active_q) && mask_q[k]) mask_above = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      echo_cnt_d   = echo_cnt_q;
      active_d     = active_q;
      ptr_d        = ptr_q;
      mask_d       = mask_q;
      tmo_flag_d   = tmo_flag_q;
      distance_d   = distance_q;
      timeout_d    = timeout_q;
      dist_valid_d = '0;
      scan_done_d  = 1'b0;
      trig_d       = '0;

      case (state_q)
         IDLE: begin
            if (enable_i && (|ch_mask_i)) state_d = SELECT;
         end
         SELECT: begin
            if (sel_found) begin
               active_d = sel_ch;
               mask_d   = ch_mask_i;
               timer_d  = CNT_W'(TRIG_CYCLES - 1);
               state_d  = TRIGGER;
            end else begin
               state_d = IDLE;
            end
         end
         TRIGGER: begin
            if (timer_q == '0) begin
               timer_d    = CNT_W'(WAIT_TIMEOUT - 1);
               tmo_flag_d = 1'b0;
               state_d    = WAIT_ECHO;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         WAIT_ECHO: begin
            if (act_echo) begin
               echo_cnt_d = CNT_W'(1);
               state_d    = COUNT;
            end else if (timer_q == '0) begin
               echo_cnt_d = '0;
               tmo_flag_d = 1'b1;
               state_d    = STORE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         COUNT: begin
            if (!act_echo) begin
               state_d = STORE;
            end else if (echo_cnt_q >= CNT_W'(ECHO_MAX - 1)) begin
               echo_cnt_d = CNT_W'(ECHO_MAX);
               tmo_flag_d = 1'b1;
               state_d    = STORE;
            end else begin
               echo_cnt_d = echo_cnt_q + 1'b1;
            end
         end
         STORE: begin
            for (int k = 0; k < N_CH; k++) begin
               if (3'(k) == active_q) begin
                  distance_d[8*k +: 8] = tmo_flag_q ? DIST_OOR
                                                    : cycles_to_cm(echo_cnt_q, CM_SCALE);
                  timeout_d[k]         = tmo_flag_q;
                  dist_valid_d[k]      = 1'b1;
               end
            end
            scan_done_d = !mask_above;
            ptr_d       = (active_q == 3'(N_CH - 1)) ? 3'd0 : active_q + 3'd1;
            timer_d     = CNT_W'(GAP_CYCLES - 1);
            state_d     = GAP;
         end
         GAP: begin
            if (timer_q == '0) begin
               state_d = enable_i ? SELECT : IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // registered so the pin is high exactly while the state register sits in TRIGGER
      for (int k = 0; k < N_CH; k++) begin
         trig_d[k] = (state_d == TRIGGER) && (3'(k) == active_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         echo_cnt_q   <= '0;
         active_q     <= '0;
         ptr_q        <= '0;
         mask_q       <= '0;
         tmo_flag_q   <= 1'b0;
         trig_q       <= '0;
         distance_q   <= {N_CH{DIST_OOR}};
         dist_valid_q <= '0;
         timeout_q    <= '0;
         scan_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         echo_cnt_q   <= echo_cnt_d;
         active_q     <= active_d;
         ptr_q        <= ptr_d;
         mask_q       <= mask_d;
         tmo_flag_q   <= tmo_flag_d;
         trig_q       <= trig_d;
         distance_q   <= distance_d;
         dist_valid_q <= dist_valid_d;
         timeout_q    <= timeout_d;
         scan_done_q  <= scan_done_d;
      end
   end

   assign bus_if.trig       = trig_q;
   assign bus_if.distance   = distance_q;
   assign bus_if.dist_valid = dist_valid_q;
   assign bus_if.timeout    = timeout_q;
   assign active_ch_o       = active_q;
   assign busy_o            = (state_q != IDLE);
   assign scan_done_o       = scan_done_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Bench for the ultrasonic scan scheduler: emulated sensors answer each trigger, a scoreboard checks stores.
module tb_ultrasonic_scan_scheduler;

   localparam int PULSE    = 0;
   localparam int NONE     = 1;
   localparam int STUCK    = 2;
   localparam int WAIT_MAX = 1000;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       enable   = 1'b0;
   logic [3:0] ch_mask  = 4'b1111;
   logic [3:0] echo_drv = 4'b0000;
   logic [2:0] act_a, act_b;
   logic       busy_a, busy_b, sd_a, sd_b;

   always #5 clk = ~clk;

   ultrasonic_scan_scheduler_if #(.N_CH(4)) bus_a ();
   ultrasonic_scan_scheduler_if #(.N_CH(4)) bus_b ();
   assign bus_a.echo = echo_drv;
   assign bus_b.echo = echo_drv;

   ultrasonic_scan_scheduler #(
      .N_CH(4), .TRIG_CYCLES(5), .WAIT_TIMEOUT(200), .ECHO_MAX(300), .GAP_CYCLES(20),
      .CM_SCALE(32'h0100_0000)
   ) dut_a (
      .clk(clk), .rst(rst), .enable_i(enable), .ch_mask_i(ch_mask), .bus_if(bus_a),
      .active_ch_o(act_a), .busy_o(busy_a), .scan_done_o(sd_a)
   );

   ultrasonic_scan_scheduler #(
      .N_CH(4), .TRIG_CYCLES(5), .WAIT_TIMEOUT(200), .ECHO_MAX(300), .GAP_CYCLES(20),
      .CM_SCALE(32'h0000_1648)
   ) dut_b (
      .clk(clk), .rst(rst), .enable_i(enable), .ch_mask_i(ch_mask), .bus_if(bus_b),
      .active_ch_o(act_b), .busy_o(busy_b), .scan_done_o(sd_b)
   );

   typedef struct {
      logic [1:0] ch;
      logic [7:0] dist_a;
      logic [7:0] dist_b;
      logic       tmo;
      logic       sd;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] exp_slot [4];
   int         n_chk      = 0;
   int         n_fail     = 0;
   logic       onehot_err = 1'b0;
   logic       stray_sd   = 1'b0;
   logic [3:0] trig_seen  = 4'b0000;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] sa, sb;
      if (!rst) begin
         if (!$onehot0(bus_a.trig)) onehot_err = 1'b1;
         trig_seen = trig_seen | bus_a.trig;
         if (sd_a && bus_a.dist_valid == 4'b0) stray_sd = 1'b1;
         if (bus_a.dist_valid != 4'b0) begin
            n_chk++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_store: dist_valid=%b with no expected entry", bus_a.dist_valid);
            end else begin
               e  = sb_q.pop_front();
               sa = 32'(bus_a.distance) >> {e.ch, 3'b000};
               sb = 32'(bus_b.distance) >> {e.ch, 3'b000};
               if (bus_a.dist_valid !== (4'b0001 << e.ch)) begin
                  n_fail++;
                  $display("FAIL dist_valid: got %b required %b", bus_a.dist_valid, 4'b0001 << e.ch);
               end
               n_chk++;
               if (sa[7:0] !== e.dist_a) begin
                  n_fail++;
                  $display("FAIL distance_ch%0d: got %0d required %0d", e.ch, sa[7:0], e.dist_a);
               end
               n_chk++;
               if (bus_a.timeout[e.ch] !== e.tmo) begin
                  n_fail++;
                  $display("FAIL timeout_ch%0d: got %b required %b", e.ch, bus_a.timeout[e.ch], e.tmo);
               end
               n_chk++;
               if (sd_a !== e.sd) begin
                  n_fail++;
                  $display("FAIL scan_done_ch%0d: got %b required %b", e.ch, sd_a, e.sd);
               end
               n_chk++;
               if (bus_b.dist_valid !== (4'b0001 << e.ch) || sb[7:0] !== e.dist_b) begin
                  n_fail++;
                  $display("FAIL default_scale_ch%0d: valid=%b dist=%0d required dist %0d",
                           e.ch, bus_b.dist_valid, sb[7:0], e.dist_b);
               end
            end
         end
      end
   end

   // waits for the trigger on ch, plays the sensor's response and waits for the store
   task automatic serve(input logic [1:0] ch, input int mode, input int len, input bit drop_en);
      int     n;
      int     hi_ch;
      exp_t   e;
      longint p;
      n = 0;
      while (bus_a.trig == 4'b0 && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (bus_a.trig !== (4'b0001 << ch)) begin
         n_fail++;
         $display("FAIL service_order: trig=%b required %b", bus_a.trig, 4'b0001 << ch);
      end
      if (bus_a.trig == 4'b0) return;
      if (drop_en) enable = 1'b0;
      if (mode == STUCK) echo_drv[ch] = 1'b1;
      n = 0;
      while (bus_a.trig != 4'b0 && n < 50) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (n != 5) begin
         n_fail++;
         $display("FAIL trig_width_ch%0d: high %0d cycles required 5", ch, n);
      end
      hi_ch = 0;
      for (int k = 0; k < 4; k++) if (ch_mask[k]) hi_ch = k;
      e.ch = ch;
      e.sd = (hi_ch == int'(ch));
      if (mode == PULSE && len < 300) begin
         e.tmo    = 1'b0;
         e.dist_a = (len > 255) ? 8'hFF : 8'(len);
         p        = (longint'(len) * 5704) >>> 24;
         e.dist_b = (p > 255) ? 8'hFF : 8'(p);
      end else begin
         e.tmo    = 1'b1;
         e.dist_a = 8'hFF;
         e.dist_b = 8'hFF;
      end
      exp_slot[ch] = e.dist_a;
      sb_q.push_back(e);
      if (mode == PULSE) begin
         repeat (10) @(posedge clk);
         #1 echo_drv[ch] = 1'b1;
         repeat (len) @(posedge clk);
         #1 echo_drv[ch] = 1'b0;
      end
      n = 0;
      while (sb_q.size() != 0 && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL store_wait_ch%0d: no dist_valid within %0d cycles", ch, WAIT_MAX);
         sb_q.delete();
      end
      if (mode == STUCK) echo_drv[ch] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_chk++;
      if (bus_a.trig !== 4'b0 || bus_a.dist_valid !== 4'b0 || bus_a.timeout !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: trig=%b valid=%b timeout=%b required all 0",
                  bus_a.trig, bus_a.dist_valid, bus_a.timeout);
      end
      n_chk++;
      if (bus_a.distance !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL reset_distance: got %h required ffffffff", bus_a.distance);
      end
      n_chk++;
      if (act_a !== 3'd0 || busy_a !== 1'b0 || sd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: active=%0d busy=%b scan_done=%b required 0/0/0", act_a, busy_a, sd_a);
      end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (busy_a !== 1'b0 || bus_a.trig !== 4'b0) begin
         n_fail++;
         $display("FAIL idle_hold: busy=%b trig=%b required 0 with enable low", busy_a, bus_a.trig);
      end
   endtask

   task automatic test_measure();
      enable = 1'b1;
      serve(2'd0, PULSE, 100, 1'b0);
      serve(2'd1, PULSE, 42,  1'b0);
      serve(2'd2, PULSE, 280, 1'b0);
      serve(2'd3, PULSE, 7,   1'b0);
   endtask

   task automatic test_timeout();
      serve(2'd0, PULSE, 10,  1'b0);
      serve(2'd1, PULSE, 20,  1'b0);
      serve(2'd2, NONE,  0,   1'b0);
      serve(2'd3, PULSE, 255, 1'b0);
      serve(2'd0, PULSE, 1,   1'b0);
      serve(2'd1, PULSE, 299, 1'b0);
      serve(2'd2, PULSE, 5,   1'b0);
      serve(2'd3, PULSE, 3,   1'b0);
   endtask

   task automatic test_stuck_echo();
      serve(2'd0, PULSE, 50,  1'b0);
      serve(2'd1, STUCK, 0,   1'b0);
      serve(2'd2, PULSE, 60,  1'b0);
      serve(2'd3, PULSE, 300, 1'b0);
   endtask

   task automatic test_mask();
      ch_mask   = 4'b1010;
      trig_seen = 4'b0000;
      serve(2'd1, PULSE, 11, 1'b0);
      serve(2'd3, PULSE, 33, 1'b0);
      serve(2'd1, PULSE, 12, 1'b0);
      serve(2'd3, PULSE, 34, 1'b0);
      n_chk++;
      if ((trig_seen & 4'b0101) !== 4'b0000) begin
         n_fail++;
         $display("FAIL masked_trig: trig seen %b required no bit of 0101", trig_seen);
      end
      n_chk++;
      if (bus_a.distance[7:0] !== exp_slot[0] || bus_a.distance[23:16] !== exp_slot[2]) begin
         n_fail++;
         $display("FAIL masked_keep: slot0=%0d slot2=%0d required %0d %0d",
                  bus_a.distance[7:0], bus_a.distance[23:16], exp_slot[0], exp_slot[2]);
      end
   endtask

   task automatic test_single();
      ch_mask = 4'b0100;
      serve(2'd2, PULSE, 21, 1'b0);
      serve(2'd2, PULSE, 22, 1'b0);
      ch_mask = 4'b1111;
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (bus_a.trig == 4'b0 && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (bus_a.trig !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_mid_order: trig=%b required 1000", bus_a.trig);
      end
      n = 0;
      while (bus_a.trig != 4'b0 && n < 50) begin @(posedge clk); #1; n++; end
      repeat (10) @(posedge clk);
      #1 echo_drv[3] = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      n_chk++;
      if (busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_busy: busy=%b required 1 while counting", busy_a);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb_q.delete();
      n_chk++;
      if (bus_a.trig !== 4'b0 || busy_a !== 1'b0 || act_a !== 3'd0 || bus_a.dist_valid !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_mid_status: trig=%b busy=%b active=%0d valid=%b required 0",
                  bus_a.trig, busy_a, act_a, bus_a.dist_valid);
      end
      n_chk++;
      if (bus_a.distance !== 32'hFFFF_FFFF || bus_b.distance !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL reset_mid_slots: a=%h b=%h required ffffffff", bus_a.distance, bus_b.distance);
      end
      echo_drv[3] = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_enable_drop();
      int n;
      serve(2'd0, PULSE, 30, 1'b1);
      n = 0;
      while (busy_a && n < 100) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_drop_idle: busy=%b required 0 after gap", busy_a);
      end
      trig_seen = 4'b0000;
      repeat (60) @(posedge clk);
      #1;
      n_chk++;
      if (trig_seen !== 4'b0000 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_drop_stop: trig seen %b busy=%b required none/0", trig_seen, busy_a);
      end
   endtask

   initial begin
      test_reset();
      test_measure();
      test_timeout();
      test_stuck_echo();
      test_mask();
      test_single();
      test_reset_mid();
      test_enable_drop();
      n_chk++;
      if (onehot_err !== 1'b0) begin
         n_fail++;
         $display("FAIL trig_onehot: more than one trig bit seen high, required at most one");
      end
      n_chk++;
      if (stray_sd !== 1'b0) begin
         n_fail++;
         $display("FAIL scan_done_align: scan_done seen without dist_valid, required aligned");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
